// File: rtl/serial_adder.sv
// Bit-serial adder: OP_A + OP_B + Cin, one bit per clock, LSB first.
// Latency: WIDTH cycles in ADD after START is accepted, then one FIN cycle with DONE high.
// Backpressure: none; START is ignored while an addition is in progress (BUSY high).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             Cin,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             BUSY,
    output logic             DONE
);

    // Enough bits to count 0..WIDTH-1; never wraps inside an operation.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] resReg;
    logic             carry;
    logic [CW-1:0]    bitCnt;

    logic             sumBit;
    logic             carryNext;
    logic             lastBit;
    logic [WIDTH-1:0] resNext;

    // Full-adder slice on the current LSBs and the next result register value.
    always_comb begin
        sumBit    = aReg[0] ^ bReg[0] ^ carry;
        carryNext = (aReg[0] & bReg[0]) | (aReg[0] & carry) | (bReg[0] & carry);
        lastBit   = (bitCnt == LAST_BIT);
        resNext   = {sumBit, resReg[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered BUSY/DONE/SUM/CO.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            aReg   <= '0;
            bReg   <= '0;
            resReg <= '0;
            carry  <= 1'b0;
            bitCnt <= '0;
            SUM    <= '0;
            CO     <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        // Operands are captured only here; later input changes are ignored.
                        aReg   <= OP_A;
                        bReg   <= OP_B;
                        carry  <= Cin;
                        resReg <= '0;
                        bitCnt <= '0;
                        BUSY   <= 1'b1;
                        state  <= ADD;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ADD: begin
                    // START is deliberately not looked at in this state.
                    resReg <= resNext;
                    aReg   <= aReg >> 1;
                    bReg   <= bReg >> 1;
                    carry  <= carryNext;
                    if (lastBit) begin
                        // Publish the result on the same edge the final bit is formed.
                        SUM   <= resNext;
                        CO    <= carryNext;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
